// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier for the M-extension datapath.
// Ports: clk, rst_n, start/ready handshake, A/B operands, busy, done pulse, 2N-bit product.

module seq_multiplier_rca #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  logic [W:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]  = (a_i[i] & b_i[i]) |
                     (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = c[W];

endmodule

module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e         state_q;
  logic [N-1:0]   m_q;
  logic [2*N-1:0] p_q;
  logic [2*N-1:0] p_d;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] prod_q;

  logic [N-1:0]   add_b;
  logic [N-1:0]   sum;
  logic           cout;
  logic           last;

  // Only add the multiplicand when the current multiplier bit is set.
  assign add_b = p_q[0] ? m_q : '0;

  seq_multiplier_rca #(
    .W (N)
  ) u_rca (
    .a_i (p_q[2*N-1:N]),
    .b_i (add_b),
    .c_i (1'b0),
    .s_o (sum),
    .c_o (cout)
  );

  // Carry becomes the new MSB; the consumed multiplier bit drops out.
  assign p_d  = {cout, sum, p_q[N-1:1]};
  assign last = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            m_q     <= A;
            p_q     <= {{N{1'b0}}, B};
            cnt_q   <= '0;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          p_q <= p_d;
          if (last) begin
            prod_q  <= p_d;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready   = (state_q != S_RUN);
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign product = prod_q;

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative unsigned shift-and-add multiplier for the CPU's M-extension datapath.
- Sits directly downstream of the ripple-carry adder stage: each cycle it feeds the running upper partial product and the multiplicand into an internal N-bit ripple-carry adder and consumes its sum and carry-out.
- Produces a 2N-bit product after N iteration cycles, using a start/done handshake toward the execute stage.

Parameters:
- N, 8, operand width in bits (core instantiates N=32); N >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a multiply; sampled only while ready=1.
- A  input  N  multiplicand, unsigned; captured on accepted start.
- B  input  N  multiplier, unsigned; captured on accepted start.
- ready  output  1  high when a start will be accepted.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse: product updated this cycle.
- product  output  2N  last completed result A*B.

Behaviour:
- Reset: asynchronous, active-low. Forces state IDLE, ready=1, busy=0, done=0, product=0, and clears the internal registers M, P, cnt.
- Reset asserted mid-operation aborts the multiply. No done pulse is issued and product reads 0.
- States:
  - IDLE: ready=1, busy=0, done=0.
  - RUN: ready=0, busy=1, done=0.
  - DONE: ready=1, busy=0, done=1.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --(cnt==N-1)--> DONE.
  - DONE --start--> RUN.
  - DONE --!start--> IDLE.
- Accept: at a rising edge with ready=1 and start=1:
  - M <= A.
  - P <= {N'b0, B}.
  - cnt <= 0.
  - state <= RUN.
- RUN iteration, one per edge:
  - Adder inputs are P[2N-1:N] and (P[0] ? M : 0), with carry-in 0. This yields sum S and carry-out c.
  - P <= {c, S, P[N-1:1]}, i.e. a logical right shift of the (N+1)-bit sum concatenated with the lower half.
  - cnt <= cnt + 1. cnt is ceil(log2(N)) bits wide and never wraps inside a run.
- Completion: the edge performing iteration N-1 also loads product <= next P value and moves to DONE.
- Latency: start accepted at edge k gives done=1 and a valid product in the cycle after edge k+N. Throughput is one multiply per N+1 cycles. Back-to-back operation adds no idle cycle.
- Product hold: product is written only at completion and holds its value through IDLE and through the next RUN until that run completes.
- Ignored start: start is ignored while busy=1; A and B may change freely during RUN without effect.
- Simultaneous events:
  - start in the DONE cycle is accepted. The done pulse still lasts exactly that one cycle, and product holds the completed value.
  - rst_n low overrides every other input.
- Width rules:
  - All arithmetic is unsigned.
  - Adder carry-out must be kept: the maximum partial sum (2^N-1)+(2^N-1) needs N+1 bits.
  - The product never overflows 2N bits.
- The adder is purely combinational inside the block. No other combinational path exists from inputs to outputs: ready, busy, done and product are decoded from registered state only.

Test Plan:
- Basic, N=8: reset, A=3, B=5, start pulse -> busy high for 8 cycles, then done=1 for exactly one cycle with product=0x000F, then ready=1, busy=0.
- Carry stress, N=8: A=0xFF, B=0xFF -> product=0xFE01 at done. Also A=0x80, B=0x02 -> product=0x0100.
- Zero and identity: A=0, B=0xAB -> product=0x0000; A=0xAB, B=1 -> product=0x00AB. Done timing is identical, N+1 cycles after accept.
- Ignored start: start a multiply of A=7, B=9; pulse start with A=2, B=2 at cycle 3 of RUN -> no restart, product=63 at the original done time. Product keeps its prior value during RUN.
- Back-to-back: hold start high with A=12, B=12, then A=10, B=20 presented in the DONE cycle -> first done shows 144, the second run begins with no idle cycle, and the second done, 9 cycles later, shows 200.
- Async reset mid-run: assert rst_n low asynchronously (between clock edges) at RUN cycle 4 -> outputs immediately reset (ready=1, busy=0, done=0, product=0), and no done pulse follows release. A subsequent 6*7 run gives product=42.
- Random, N=8 and N=32: 1000 random pairs compared against a reference A*B model; done spacing checked at exactly N+1 cycles.
